led_share_scheduler: RTL and testbench
======================================

# led_share_scheduler

Time-multiplexes the board's 10-bit LEDR bank between up to four internal requesters (pattern generators, status displays, key-echo logic). Each requester raises a request and gets LEDR for a fixed time slot. Grants follow a round-robin, one-hot, registered policy, and a freeze input can stretch the current slot indefinitely. The block sits between the requesting logic and the top-level LEDR pins, so the LED bank has exactly one driver.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 10: LED bus width.
- SLOT, 8: slot length in clk cycles, ≥2.
- IDLE_PAT, 10'b0: LEDR value driven when no requester owns the bank.

Ports:
- clk, input, 1: single system clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, N_REQ: per-requester level request; bit i belongs to requester i.
- data, input, N_REQ*WIDTH: requester i's pattern is data[i*WIDTH +: WIDTH].
- freeze, input, 1: while high, the slot counter holds its value.
- gnt, output, N_REQ: one-hot grant, or all zero when idle.
- ledr, output, WIDTH: registered LED drive.
- busy, output, 1: high whenever any gnt bit is high.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner index o is valid.
- Reset values:
  - gnt = 0, ledr = IDLE_PAT, busy = 0.
  - State is IDLE, slot counter = 0.
  - last = N_REQ-1, so requester 0 wins first.
- Round-robin pick:
  - Search starts at (last+1) mod N_REQ and wraps.
  - The first set req bit wins.
- IDLE → OWN:
  - Transition occurs when any req bit is set.
  - Winner w is chosen by the pick; o = w, last = w, counter = 0.
- In OWN, each cycle:
  - ledr ← data[o].
  - Counter increments unless freeze = 1.
- Slot end occurs on either of these conditions:
  - counter == SLOT-1 while freeze = 0;
  - req[o] == 0 (owner release). Release is honoured even while freeze is high.
- At slot end:
  - If another requester's req is set, switch straight to the pick winner. There is no idle cycle between owners, and the counter resets to 0.
  - Otherwise, if req[o] is still set, re-grant o for a fresh slot.
  - Otherwise, go to IDLE and drive ledr ← IDLE_PAT.
- Simultaneous slot expiry and owner release is treated as a release; the pick excludes no one, but req[o] = 0 means o cannot win.
- Requests arriving mid-slot wait; there is no pre-emption.
- Reset mid-slot returns every output to its reset value on the next edge.

## Timing
- Grant latency:
  - req rising in IDLE at edge k → gnt and busy high after edge k+1.
  - ledr shows data[w] after edge k+1, because the pattern is captured at the same edge as the grant.
- Data latency: a change on data[o] appears on ledr one cycle later.
- Slot length with freeze = 0 and req held: gnt stays on o for exactly SLOT cycles, then moves on the next edge.
- Release latency: req[o] falling at edge k → gnt[o] low after edge k+1, with the new owner or IDLE_PAT on the same edge.
- Invariants: gnt always has at most one bit set; ledr never shows an unowned requester's data.

## Structure
- Shared package led_share_pkg holds:
  - the state encoding (ST_IDLE, ST_OWN);
  - IDX_W = $clog2(N_REQ);
  - CNT_W = $clog2(SLOT).
- Sub-module rr_pick is purely combinational:
  - inputs: req and last;
  - outputs: winner index and valid.
- The top level holds the FSM, counter, owner/last registers and the ledr mux register.

## Test plan
- Reset and idle:
  - Assert rst for 2 cycles with all req = 0.
  - Required: gnt = 0000, busy = 0, ledr = 0 throughout, including while freeze toggles.
- Single requester, SLOT = 8:
  - req = 0100 held, data[2] = 10'h2AA.
  - Required: gnt = 0100 one cycle after req and stays continuous (re-granted every 8 cycles).
  - Required: ledr = 2AA; changing data[2] to 155 shows on ledr one cycle later.
- Round-robin fairness:
  - req = 1111 held from reset.
  - Required grant order 0,1,2,3,0; each grant lasts 8 cycles with no idle gaps; gnt is one-hot every cycle.
- Early release and wrap:
  - Owner 3 drops req at cycle 3 of its slot while req[1] is set.
  - Required: gnt = 0010 on the next edge, counter restarts, and the next pick searches from 0.
- Freeze:
  - Owner 0 with req = 0011; hold freeze = 1 for 20 cycles mid-slot.
  - Required: gnt stays 0001 for the 20 cycles, and the slot then finishes its remaining count.
  - Then repeat with req[0] dropping during freeze. Required: gnt moves to 0010 one cycle later.
- Reset mid-operation:
  - Assert rst while gnt = 0100.
  - Required: next edge gives gnt = 0, ledr = IDLE_PAT; after release with req = 1111, the first grant goes to requester 0.

Source files
------------

// File: rtl/led_share_pkg.sv
// Shared definitions for the LED bank scheduler: state encoding, default
// geometry and the width helper used to size index and counter registers.
package led_share_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_SLOT  = 8;
    localparam int IDX_W     = $clog2(DEF_N_REQ);
    localparam int CNT_W     = $clog2(DEF_SLOT);

    // Register width for values 0..n-1, never narrower than one bit
    function automatic int ceil_log2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_share_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping,
// with 'last' itself considered at the very end.
module rr_pick
    import led_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = IDX_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    // Walk from the farthest candidate to the nearest so the nearest set bit wins
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (req[idx]) begin
                winner = IW'(idx);
                valid  = 1'b1;
            end else begin
                winner = winner;
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/led_share_scheduler.sv
// Time-multiplexes one LED bank between N_REQ requesters with round-robin,
// fixed-length, freezable slots; all outputs are registered.
module led_share_scheduler
    import led_share_pkg::*;
#(
    parameter int               N_REQ    = DEF_N_REQ,
    parameter int               WIDTH    = 10,
    parameter int               SLOT     = DEF_SLOT,
    parameter logic [WIDTH-1:0] IDLE_PAT = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data,
    input  logic                     freeze,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         ledr,
    output logic                     busy
);

    localparam int IW = ceil_log2(N_REQ);
    localparam int CW = ceil_log2(SLOT);

    state_e           state_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    last_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    win_s;
    logic             win_valid_s;
    logic             slot_end_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (win_s),
        .valid  (win_valid_s)
    );

    // Release wins over freeze; expiry only counts while the counter is running
    assign slot_end_s = !req[owner_q] || (!freeze && (cnt_q == CW'(SLOT - 1)));

    // Scheduler FSM: owner, slot counter, grant and LED drive registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
            gnt     <= '0;
            ledr    <= IDLE_PAT;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OWN: begin
                    // Because last == owner, the pick prefers any other requester
                    // and only falls back to re-granting the owner.
                    if ((state_q == ST_IDLE) || slot_end_s) begin
                        if (win_valid_s) begin
                            state_q <= ST_OWN;
                            owner_q <= win_s;
                            last_q  <= win_s;
                            cnt_q   <= '0;
                            gnt     <= N_REQ'(1) << win_s;
                            ledr    <= data[win_s*WIDTH +: WIDTH];
                            busy    <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            gnt     <= '0;
                            ledr    <= IDLE_PAT;
                            busy    <= 1'b0;
                        end
                    end else begin
                        if (!freeze) begin
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            cnt_q <= cnt_q;
                        end
                        ledr <= data[owner_q*WIDTH +: WIDTH];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    gnt     <= '0;
                    ledr    <= IDLE_PAT;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_share_scheduler.sv
// Randomized self-checking bench for led_share_scheduler against a
// slot-accounting reference model.
module tb_led_share_scheduler;

    localparam int N = 4;
    localparam int W = 10;
    localparam int SLOT = 8;
    localparam logic [W-1:0] IDLE = 10'b0;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   data;
    logic             freeze;
    logic [N-1:0]     gnt;
    logic [W-1:0]     ledr;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 = none), last winner, non-frozen cycles used
    int           m_owner = -1;
    int           m_last  = N - 1;
    int           m_used  = 0;
    logic [W-1:0] m_ledr  = IDLE;

    led_share_scheduler #(
        .N_REQ    (N),
        .WIDTH    (W),
        .SLOT     (SLOT),
        .IDLE_PAT (IDLE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .freeze (freeze),
        .gnt    (gnt),
        .ledr   (ledr),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_after(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] pattern_of(input int i);
        logic [N*W-1:0] d;
        d = data;
        return d[i*W +: W];
    endfunction

    task automatic model_grant(input int w);
        if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_used  = 0;
            m_ledr  = pattern_of(w);
        end else begin
            m_owner = -1;
            m_ledr  = IDLE;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_used  = 0;
            m_ledr  = IDLE;
        end else if (m_owner < 0) begin
            model_grant(pick_after(req, m_last));
        end else begin
            if (!freeze) m_used++;
            if (!req[m_owner] || m_used == SLOT) model_grant(pick_after(req, m_last));
            else m_ledr = pattern_of(m_owner);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_update();
        #1;
        exp_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check_value("gnt", 32'(gnt), 32'(exp_gnt));
        check_value("ledr", 32'(ledr), 32'(m_ledr));
        check_value("busy", 32'(busy), 32'(m_owner >= 0));
        check_value("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic wait_owner(input string tag, input int who, input int used);
        int n;
        n = 0;
        while (!(m_owner == who && m_used == used) && n < 200) begin
            step();
            n++;
        end
        check_value(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic rand_data();
        data = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1; req = '0; freeze = 1'b0;
        rand_data();
        // reset and idle with freeze toggling
        for (int i = 0; i < 2; i++) begin freeze = 1'($urandom); step(); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin freeze = 1'($urandom); step(); end
        freeze = 1'b0;
        // single requester, continuous re-grant, data latency
        req = 4'b0100;
        data[2*W +: W] = 10'h2AA;
        repeat (20) step();
        data[2*W +: W] = 10'h155;
        repeat (6) step();
        // round-robin fairness from reset
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        repeat (40) step();
        // early release by owner 3 at cycle 3 while req[1] is set
        wait_owner("wait_own3", 3, 2);
        req = 4'b0010;
        repeat (12) step();
        // freeze mid-slot, then resume
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0011;
        repeat (3) step();
        freeze = 1'b1;
        repeat (20) step();
        freeze = 1'b0;
        repeat (12) step();
        // release during freeze
        wait_owner("wait_own0", 0, 3);
        freeze = 1'b1;
        repeat (4) step();
        req[0] = 1'b0;
        repeat (3) step();
        freeze = 1'b0;
        repeat (4) step();
        // reset while requester 2 owns the bank
        req = 4'b1111;
        wait_owner("wait_own2", 2, 4);
        rst = 1'b1; step(); rst = 1'b0;
        repeat (10) step();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 11) == 0) freeze = ~freeze;
            if ($urandom_range(0, 3) == 0) rand_data();
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
